// File: rtl/lsu_mem_if.sv
// lsu_mem_if: data-memory request/grant/response channel between the LSU and data memory.
interface lsu_mem_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    modport master(output dm_req, dm_we, dm_addr, dm_be, dm_wdata, input dm_gnt, dm_rvalid, dm_rdata);
    modport slave(input dm_req, dm_we, dm_addr, dm_be, dm_wdata, output dm_gnt, dm_rvalid, dm_rdata);
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store unit running the data-memory req/gnt/rvalid handshake.
// Define LSU_MISALIGN_EXC_EN to flag misaligned half/word accesses instead of aligning them down.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DM_read,
    input  logic        DM_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic        misalign_exc,
    lsu_mem_if.master   dm
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          we_q;
    logic          access, is_byte, is_half, misaligned, accept, timed_out;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n, ext_data;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    assign access  = DM_read | DM_write;
    // Store codes other than SB/SH are words; load codes 100/101 are the unsigned byte/half.
    assign is_byte = DM_write ? funct3 == 3'b000 : funct3[1:0] == 2'b00;
    assign is_half = DM_write ? funct3 == 3'b001 : funct3[1:0] == 2'b01;
`ifdef LSU_MISALIGN_EXC_EN
    assign misaligned   = is_half ? mem_addr[0] : !is_byte && mem_addr[1:0] != 2'b00;
    assign misalign_exc = state == IDLE && access && misaligned;
`else
    assign misaligned   = 1'b0;
    assign misalign_exc = 1'b0;
`endif
    assign accept    = state == IDLE && access && !misaligned;
    assign lsu_stall = accept || state == REQ || state == WAIT;
    assign timed_out = cnt == CW'(TIMEOUT_CYC - 1);
    assign be_n    = !DM_write ? 4'hF : is_byte ? 4'b0001 << mem_addr[1:0] : is_half ? (mem_addr[1] ? 4'hC : 4'h3) : 4'hF;
    assign wdata_n = !DM_write ? 32'h0 : is_byte ? {4{store_data[7:0]}} : is_half ? {2{store_data[15:0]}} : store_data;
    assign byte_sel = 8'(dm.dm_rdata >> {off_q, 3'b000});
    assign half_sel = off_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    assign ext_data = f3_q[1:0] == 2'b00 ? {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel} :
                      f3_q[1:0] == 2'b01 ? {{16{half_sel[15] & ~f3_q[2]}}, half_sel} : dm.dm_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= '0;
            dm.dm_be    <= '0;
            dm.dm_wdata <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state       <= REQ;
                    cnt         <= '0;
                    f3_q        <= funct3;
                    off_q       <= mem_addr[1:0];
                    we_q        <= DM_write;
                    dm.dm_req   <= 1'b1;
                    dm.dm_we    <= DM_write;
                    dm.dm_addr  <= {mem_addr[31:2], 2'b00};
                    dm.dm_be    <= be_n;
                    dm.dm_wdata <= wdata_n;
                end
                REQ: if (dm.dm_gnt || timed_out) begin
                    state      <= dm.dm_gnt && !we_q ? WAIT : DONE;
                    cnt        <= '0;
                    dm.dm_req  <= 1'b0;
                    bus_err    <= !dm.dm_gnt;
                    load_valid <= !dm.dm_gnt && !we_q;
                end else cnt <= cnt + 1'b1;
                WAIT: if (dm.dm_rvalid || timed_out) begin
                    state      <= DONE;
                    bus_err    <= !dm.dm_rvalid;
                    load_valid <= 1'b1;
                    load_data  <= dm.dm_rvalid ? ext_data : '0;
                end else cnt <= cnt + 1'b1;
                DONE: begin
                    state      <= IDLE;
                    bus_err    <= 1'b0;
                    load_valid <= 1'b0;
                    load_data  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: schedule-driven bench; each transaction's per-cycle outputs are derived from its gnt/rvalid delays.
module tb_lsu_mem_ctrl;
    localparam int TO = 5;
    logic clk = 1'b0, rst_n = 1'b0;
    logic rd_i = 1'b0, wr_i = 1'b0, gnt_i = 1'b0, rv_i = 1'b0;
    logic [2:0] f3_i = '0;
    logic [31:0] addr_i = '0, sd_i = '0, rdat_i = '0;
    logic lsu_stall, load_valid, bus_err, misalign_exc;
    logic [31:0] load_data;
    logic e_stall = 0, e_req = 0, e_lv = 0, e_err = 0, e_mis = 0, e_fld = 0, e_we = 0;
    logic [31:0] e_ld = '0, e_addr = '0, e_wd = '0;
    logic [3:0] e_be = '0;
    int total = 0, bad = 0, cyc_no = 0, stall_tot = 0, req_tot = 0, lv_tot = 0, mis_tot = 0, lv_cyc = 0;
    logic [31:0] seen_addr = '0, seen_wd = '0, seen_ld = '0;
    logic [3:0] seen_be = '0;
    logic seen_err = 0, seen_lv = 0;

    always #5 clk = ~clk;

    lsu_mem_if mif();
    assign mif.dm_gnt    = gnt_i;
    assign mif.dm_rvalid = rv_i;
    assign mif.dm_rdata  = rdat_i;

    lsu_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .DM_read(rd_i), .DM_write(wr_i), .funct3(f3_i),
        .mem_addr(addr_i), .store_data(sd_i), .lsu_stall(lsu_stall), .load_data(load_data),
        .load_valid(load_valid), .bus_err(bus_err), .misalign_exc(misalign_exc), .dm(mif.master)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] f, input logic [1:0] off, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * off)) & 32'hFF;
        h = off[1] ? (r >> 16) : (r & 32'hFFFF);
        if (f == 3'b000) return b[7] ? (b | 32'hFFFFFF00) : b;
        if (f == 3'b100) return b;
        if (f == 3'b001) return h[15] ? (h | 32'hFFFF0000) : h;
        if (f == 3'b101) return h;
        return r;
    endfunction

    always @(negedge clk) begin
        cyc_no++;
        chk("stall", 32'(lsu_stall), 32'(e_stall));
        chk("dm_req", 32'(mif.dm_req), 32'(e_req));
        chk("load_valid", 32'(load_valid), 32'(e_lv));
        chk("bus_err", 32'(bus_err), 32'(e_err));
        chk("load_data", load_data, e_ld);
        chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
        if (e_fld) begin
            chk("dm_addr", mif.dm_addr, e_addr);
            chk("dm_be", 32'(mif.dm_be), 32'(e_be));
            chk("dm_we", 32'(mif.dm_we), 32'(e_we));
            if (e_we) chk("dm_wdata", mif.dm_wdata, e_wd);
        end
        stall_tot += 32'(lsu_stall);
        req_tot   += 32'(mif.dm_req);
        lv_tot    += 32'(load_valid);
        mis_tot   += 32'(misalign_exc);
        if (mif.dm_req) begin
            seen_addr = mif.dm_addr;
            seen_be   = mif.dm_be;
            seen_wd   = mif.dm_wdata;
        end
        if (load_valid || bus_err) begin
            seen_ld  = load_data;
            seen_err = bus_err;
            seen_lv  = load_valid;
            lv_cyc   = cyc_no;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        gnt_i  = 1'($urandom);
        rv_i   = 1'($urandom);
        rdat_i = $urandom;
    endtask

    task automatic bubble();
        rd_i = 0; wr_i = 0;
        e_stall = 0; e_req = 0; e_fld = 0; e_lv = 0; e_err = 0; e_ld = '0; e_mis = 0;
        noise();
        tick();
    endtask

    task automatic run_txn(input logic wr, input logic rd, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input int gdel, input int rdel, input logic [31:0] rdat);
        int sz, nreq, nw;
        logic mis, granted, got;
        sz = wr ? (f == 3'b000 ? 0 : f == 3'b001 ? 1 : 2) : (f[1:0] == 2'b00 ? 0 : f[1:0] == 2'b01 ? 1 : 2);
        mis = 0;
`ifdef LSU_MISALIGN_EXC_EN
        mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`endif
        rd_i = rd; wr_i = wr; f3_i = f; addr_i = a; sd_i = d;
        e_lv = 0; e_err = 0; e_ld = '0; e_fld = 0; e_req = 0;
        e_we   = wr;
        e_addr = {a[31:2], 2'b00};
        e_be   = !wr ? 4'hF : sz == 0 ? 4'b0001 << a[1:0] : sz == 1 ? (a[1] ? 4'hC : 4'h3) : 4'hF;
        e_wd   = sz == 0 ? {4{d[7:0]}} : sz == 1 ? {2{d[15:0]}} : d;
        if (mis) begin
            e_stall = 0; e_mis = 1;
            repeat (2) begin noise(); tick(); end
            e_mis = 0;
            return;
        end
        e_stall = 1;
        noise();
        tick();
        granted = gdel < TO;
        nreq = granted ? gdel + 1 : TO;
        e_req = 1; e_fld = 1;
        for (int i = 1; i <= nreq; i++) begin
            gnt_i = (i == gdel + 1); rv_i = 1'($urandom); rdat_i = $urandom;
            tick();
        end
        e_req = 0; e_fld = 0; got = 1;
        if (granted && !wr) begin
            got = rdel < TO;
            nw = got ? rdel + 1 : TO;
            for (int j = 1; j <= nw; j++) begin
                gnt_i = 1'($urandom); rv_i = (j == rdel + 1); rdat_i = rv_i ? rdat : $urandom;
                tick();
            end
        end
        e_stall = 0;
        e_err = !(granted && got);
        e_lv = !wr;
        e_ld = (!wr && !e_err) ? ld_model(f, a[1:0], rdat) : 32'h0;
        noise();
        tick();
        e_lv = 0; e_err = 0; e_ld = '0;
    endtask

    initial begin
        int s0, r0, c0, l0, m0;
        tick(); tick();
        chk("rst_addr", mif.dm_addr, 32'h0);
        chk("rst_be", 32'(mif.dm_be), 32'h0);
        chk("rst_wdata", mif.dm_wdata, 32'h0);
        rst_n = 1;
        bubble();

        s0 = stall_tot;
        run_txn(1, 0, 3'b000, 32'h1002, 32'h11223344, 0, 0, 32'h0);
        chk("sb_stall_cycles", 32'(stall_tot - s0), 32'd2);
        chk("sb_be", 32'(seen_be), 32'h4);
        chk("sb_wdata", seen_wd, 32'h44444444);
        chk("sb_addr", seen_addr, 32'h1000);

        c0 = cyc_no;
        run_txn(0, 1, 3'b000, 32'h2003, 32'h0, 0, 0, 32'h80FFFF7F);
        chk("lb_data", seen_ld, 32'hFFFFFF80);
        chk("lb_latency", 32'(lv_cyc - c0 - 1), 32'd3);
        run_txn(0, 1, 3'b100, 32'h2003, 32'h0, 0, 0, 32'h80FFFF7F);
        chk("lbu_data", seen_ld, 32'h00000080);
        run_txn(0, 1, 3'b101, 32'h2002, 32'h0, 0, 0, 32'h80FFFF7F);
        chk("lhu_data", seen_ld, 32'h000080FF);
        run_txn(1, 1, 3'b001, 32'h2002, 32'hAAAA5678, 0, 0, 32'h0);
        chk("sh_both_strobes_be", 32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wd, 32'h56785678);

        s0 = stall_tot; r0 = req_tot;
        run_txn(1, 0, 3'b010, 32'h3000, 32'hDEADBEEF, 4, 0, 32'h0);
        chk("gdel4_req_cycles", 32'(req_tot - r0), 32'd5);
        chk("gdel4_stall_cycles", 32'(stall_tot - s0), 32'd6);

        c0 = cyc_no;
        run_txn(0, 1, 3'b010, 32'h4000, 32'h0, 0, 1000, 32'h12345678);
        chk("rto_err", 32'(seen_err), 32'd1);
        chk("rto_valid", 32'(seen_lv), 32'd1);
        chk("rto_data", seen_ld, 32'h0);
        chk("rto_latency", 32'(lv_cyc - c0 - 1), 32'(2 + TO));
        run_txn(1, 0, 3'b010, 32'h4000, 32'h1, 1000, 0, 32'h0);
        chk("gto_err", 32'(seen_err), 32'd1);
        chk("gto_valid", 32'(seen_lv), 32'd0);

        rd_i = 1; wr_i = 0; f3_i = 3'b010; addr_i = 32'h5000;
        e_stall = 1; e_req = 0; e_fld = 0; gnt_i = 0; rv_i = 0;
        tick();
        e_req = 1; e_fld = 1; e_we = 0; e_addr = 32'h5000; e_be = 4'hF; gnt_i = 1;
        tick();
        e_req = 0; e_fld = 0; gnt_i = 0;
        tick();
        rst_n = 0; rd_i = 0; e_stall = 0;
        #1;
        chk("rst_mid_stall", 32'(lsu_stall), 32'h0);
        chk("rst_mid_req", 32'(mif.dm_req), 32'h0);
        chk("rst_mid_addr", mif.dm_addr, 32'h0);
        chk("rst_mid_be", 32'(mif.dm_be), 32'h0);
        tick();
        l0 = lv_tot;
        rst_n = 1; rv_i = 1; rdat_i = 32'hFFFFFFFF;
        tick();
        rv_i = 0;
        tick(); tick();
        chk("late_rvalid_ignored", 32'(lv_tot - l0), 32'h0);

        m0 = mis_tot; r0 = req_tot;
        run_txn(0, 1, 3'b010, 32'h1001, 32'h0, 0, 0, 32'hCAFEBABE);
`ifdef LSU_MISALIGN_EXC_EN
        chk("mis_flag_cycles", 32'(mis_tot - m0), 32'd2);
        chk("mis_no_req", 32'(req_tot - r0), 32'd0);
`else
        chk("mis_off_addr", seen_addr, 32'h1000);
        chk("mis_off_data", seen_ld, 32'hCAFEBABE);
        chk("mis_off_flag", 32'(mis_tot - m0), 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic w;
            int g, r;
            w = 1'($urandom);
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 1));
            run_txn(w, w ? 1'($urandom) : 1'b1, 3'($urandom), $urandom, $urandom, g, r, $urandom);
            if ($urandom_range(0, 3) == 0) bubble();
        end
        bubble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
